// File: rtl/keypad_player.sv
// Plays a latched hex-digit sequence (plus optional enter) onto the lock
// keypad push-button lines; ports: hz100, reset, start, digits, count, send_enter -> pb, busy, done.
module keypad_player #(
  parameter int HOLD = 4,
  parameter int GAP  = 4
) (
  input  logic        hz100,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] digits,
  input  logic [3:0]  count,
  input  logic        send_enter,
  output logic [19:0] pb,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS,
    S_GAP,
    S_FIN
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP - 1);

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [3:0]  left, left_n;
  logic [31:0] dig, dig_n;
  logic        ent, ent_n;
  logic [3:0]  clamp;

  logic [19:0] pb_n;
  logic        busy_n, done_n;
  logic [2:0]  idx;
  logic [3:0]  key;

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      left  <= '0;
      dig   <= '0;
      ent   <= 1'b0;
      pb    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      left  <= left_n;
      dig   <= dig_n;
      ent   <= ent_n;
      pb    <= pb_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  // left = keys still to play, including the one being pressed;
  // it drops when a press ends, so GAP knows whether more remain.
  always_comb begin
    clamp   = (count > 4'd8) ? 4'd8 : count;
    state_n = state;
    cnt_n   = cnt;
    left_n  = left;
    dig_n   = dig;
    ent_n   = ent;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          dig_n   = digits;
          ent_n   = send_enter;
          left_n  = clamp + {3'b000, send_enter};
          cnt_n   = '0;
          state_n = (left_n == 4'd0) ? S_FIN : S_PRESS;
        end
      end
      S_PRESS: begin
        if (cnt == HOLD_LAST) begin
          cnt_n   = '0;
          left_n  = left - 4'd1;
          state_n = S_GAP;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n   = '0;
          state_n = (left == 4'd0) ? S_FIN : S_PRESS;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      S_FIN: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they can be registered
  // and still line up with the state they describe.
  // Enter is always the final key; digits before it go high to low.
  always_comb begin
    pb_n   = '0;
    busy_n = 1'b0;
    done_n = 1'b0;
    idx    = 3'(left_n - 4'd1 - {3'b000, ent_n});
    key    = dig_n[{idx, 2'b00} +: 4];
    unique case (state_n)
      S_PRESS: begin
        busy_n = 1'b1;
        if (ent_n && left_n == 4'd1) pb_n[16] = 1'b1;
        else pb_n = 20'd1 << key;
      end
      S_GAP: busy_n = 1'b1;
      S_FIN: done_n = 1'b1;
      S_IDLE: ;
    endcase
  end

endmodule
